// File: rtl/gost89_cfb_seg_if.sv
// gost89_cfb_seg_if
// Streaming and IV-control bundle for gost89_cfb_seg.
//   iv_load / iv / decrypt : load a new feedback value and latch the direction
//   in_valid / in_ready / in_data    : input segment handshake (SEG_W bits)
//   out_valid / out_ready / out_data : result segment handshake (SEG_W bits)
// master = the side feeding segments in, slave = the cipher block.
interface gost89_cfb_seg_if #(
  parameter int SEG_W = 64
) ();
  logic             iv_load;
  logic [63:0]      iv;
  logic             decrypt;
  logic             in_valid;
  logic             in_ready;
  logic [SEG_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [SEG_W-1:0] out_data;

  modport master (
    output iv_load, iv, decrypt, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  iv_load, iv, decrypt, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/gost89_cfb_seg.sv
// gost89_cfb_seg
// GOST 28147-89 cipher-feedback block with SEG_W-bit segments (8/16/32/64).
// One instance encrypts or decrypts; the direction is latched on iv_load.
// The gamma G = E_K(fb) comes from an embedded gost89_ecb_encrypt core; the
// top SEG_W bits of G are XORed onto the input segment, and the ciphertext
// side of the exchange is shifted into the feedback register.
//
// Ports (gost89_cfb_seg):
//   clk, reset : clock, synchronous active-high reset
//   sbox[511:0], key[255:0] : cipher parameters, passed straight to the core;
//                             must stay stable while a segment is in flight
//   bus        : gost89_cfb_seg_if.slave (IV control + in/out handshakes)
//   busy       : high whenever the FSM is not IDLE
//   seg_count  : (only with GOST89_CFB_SEGCNT_EN) completed-segment counter,
//                cleared by reset and iv_load, wraps at 2^32
//
// Optional feature macro: GOST89_CFB_SEGCNT_EN

// gost89_ecb_encrypt: one Feistel round per clock, 32 rounds.
//   load_data takes precedence over reset so the wrapper can pulse both.
//   blk_out is valid once busy has fallen after a load.
//   Half-block convention: N1 = blk_in[31:0], N2 = blk_in[63:32]; key word
//   K0 is key[255:224]; S-box b entry v is sbox[(b*16+v)*4 +: 4].
module gost89_ecb_encrypt (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_data,
  input  logic [511:0] sbox,
  input  logic [255:0] key,
  input  logic [63:0]  blk_in,
  output logic [63:0]  blk_out,
  output logic         busy
);
  logic [31:0] n1_q, n1_d;
  logic [31:0] n2_q, n2_d;
  logic [4:0]  round_q, round_d;
  logic        busy_q, busy_d;
  logic [2:0]  kidx;
  logic [31:0] kword;
  logic [31:0] sum;
  logic [31:0] sub;
  logic [31:0] f;

  // Rounds 0..23 walk K0..K7 forward three times, rounds 24..31 walk K7..K0.
  assign kidx  = (round_q[4:3] == 2'b11) ? ~round_q[2:0] : round_q[2:0];
  assign kword = key[{~kidx, 5'b00000} +: 32];
  assign sum   = n1_q + kword;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_sbox
      logic [8:0] idx;
      assign idx = {3'(gi), sum[4*gi +: 4], 2'b00};
      assign sub[4*gi +: 4] = sbox[idx +: 4];
    end
  endgenerate

  assign f = {sub[20:0], sub[31:21]};  // rotate left by 11

  always_comb begin
    n1_d    = n1_q;
    n2_d    = n2_q;
    round_d = round_q;
    busy_d  = busy_q;
    if (load_data) begin
      n1_d    = blk_in[31:0];
      n2_d    = blk_in[63:32];
      round_d = 5'd0;
      busy_d  = 1'b1;
    end else if (reset) begin
      round_d = 5'd0;
      busy_d  = 1'b0;
    end else if (busy_q) begin
      n1_d    = n2_q ^ f;
      n2_d    = n1_q;
      round_d = round_q + 5'd1;
      if (round_q == 5'd31) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    n1_q    <= n1_d;
    n2_q    <= n2_d;
    round_q <= round_d;
    busy_q  <= busy_d;
  end

  // Swapping the halves back undoes the exchange of the final round.
  assign blk_out = {n1_q, n2_q};
  assign busy    = busy_q;
endmodule

module gost89_cfb_seg #(
  parameter int SEG_W = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [511:0]   sbox,
  input  logic [255:0]   key,
  gost89_cfb_seg_if.slave bus,
  output logic           busy
`ifdef GOST89_CFB_SEGCNT_EN
  ,
  output logic [31:0]    seg_count
`endif
);
  generate
    if (!(SEG_W == 8 || SEG_W == 16 || SEG_W == 32 || SEG_W == 64)) begin : g_bad_seg_w
      $error("gost89_cfb_seg: SEG_W must be 8, 16, 32 or 64");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;

  state_t           state_q, state_d;
  logic [63:0]      fb_q, fb_d;
  logic             mode_q, mode_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic [SEG_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;

  logic             core_rst;
  logic             core_load;
  logic             core_busy;
  logic [63:0]      core_out;
  logic [SEG_W-1:0] result;
  logic [SEG_W-1:0] fb_c;
  logic [63:0]      fb_next;

  // START restarts the core from fb_q; load is masked during a global reset
  // so an aborted START does not leave the core running.
  assign core_load = (state_q == START) && !reset;
  assign core_rst  = reset || (state_q == START);

  gost89_ecb_encrypt u_core (
    .clk       (clk),
    .reset     (core_rst),
    .load_data (core_load),
    .sbox      (sbox),
    .key       (key),
    .blk_in    (fb_q),
    .blk_out   (core_out),
    .busy      (core_busy)
  );

  assign result = seg_q ^ core_out[63 -: SEG_W];
  // Ciphertext is what feeds back: our output when encrypting, our input
  // when decrypting.
  assign fb_c   = mode_q ? seg_q : result;

  generate
    if (SEG_W == 64) begin : g_fb_full
      assign fb_next = fb_c;
    end else begin : g_fb_shift
      assign fb_next = {fb_q[63-SEG_W:0], fb_c};
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    fb_d        = fb_q;
    mode_d      = mode_q;
    seg_d       = seg_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        // An IV load wins over a simultaneous segment, which stays unconsumed.
        if (bus.iv_load) begin
          fb_d   = bus.iv;
          mode_d = bus.decrypt;
        end else if (bus.in_valid) begin
          seg_d   = bus.in_data;
          state_d = START;
        end
      end
      START: begin
        state_d = WAIT;
      end
      WAIT: begin
        // The core is already busy on the first WAIT cycle, so busy low here
        // means the gamma for this segment is ready.
        if (!core_busy) begin
          out_data_d  = result;
          fb_d        = fb_next;
          out_valid_d = 1'b1;
          state_d     = OUT;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      fb_q        <= 64'd0;
      mode_q      <= 1'b0;
      seg_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fb_q        <= fb_d;
      mode_q      <= mode_d;
      seg_q       <= seg_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && !bus.iv_load;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = (state_q != IDLE);

`ifdef GOST89_CFB_SEGCNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == IDLE) && bus.iv_load) begin
      cnt_d = 32'd0;
    end else if (out_valid_q && bus.out_ready) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign seg_count = cnt_q;
`endif
endmodule

// File: tb/tb_gost89_cfb_seg.sv
// Self-checking bench for gost89_cfb_seg: three instances (SEG_W = 64, 8, 32)
// share clock and reset; a selector routes the driver to one of them.
module tb_gost89_cfb_seg;
  logic         clk;
  logic         reset;
  logic [511:0] sbox_c;
  logic [255:0] key_c;

  int checks;
  int failures;

  localparam logic [63:0] IV0 = 64'h0123456789ABCDEF;
  localparam logic [63:0] IV1 = 64'hFEDCBA9876543210;
  localparam logic [63:0] IV2 = 64'h0F1E2D3C4B5A6978;

  gost89_cfb_seg_if #(.SEG_W(64)) b64 ();
  gost89_cfb_seg_if #(.SEG_W(8))  b8 ();
  gost89_cfb_seg_if #(.SEG_W(32)) b32 ();

  logic busy64, busy8, busy32;
`ifdef GOST89_CFB_SEGCNT_EN
  logic [31:0] cnt64, cnt8, cnt32;
`endif

  gost89_cfb_seg #(.SEG_W(64)) dut64 (
    .clk(clk), .reset(reset), .sbox(sbox_c), .key(key_c), .bus(b64), .busy(busy64)
`ifdef GOST89_CFB_SEGCNT_EN
    , .seg_count(cnt64)
`endif
  );
  gost89_cfb_seg #(.SEG_W(8)) dut8 (
    .clk(clk), .reset(reset), .sbox(sbox_c), .key(key_c), .bus(b8), .busy(busy8)
`ifdef GOST89_CFB_SEGCNT_EN
    , .seg_count(cnt8)
`endif
  );
  gost89_cfb_seg #(.SEG_W(32)) dut32 (
    .clk(clk), .reset(reset), .sbox(sbox_c), .key(key_c), .bus(b32), .busy(busy32)
`ifdef GOST89_CFB_SEGCNT_EN
    , .seg_count(cnt32)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver, routed to the selected instance only.
  int          sel;
  logic        drv_in_valid, drv_out_ready, drv_iv_load, drv_decrypt;
  logic [63:0] drv_in_data, drv_iv;

  assign b64.in_valid  = (sel == 64) && drv_in_valid;
  assign b8.in_valid   = (sel == 8)  && drv_in_valid;
  assign b32.in_valid  = (sel == 32) && drv_in_valid;
  assign b64.out_ready = (sel == 64) && drv_out_ready;
  assign b8.out_ready  = (sel == 8)  && drv_out_ready;
  assign b32.out_ready = (sel == 32) && drv_out_ready;
  assign b64.iv_load   = (sel == 64) && drv_iv_load;
  assign b8.iv_load    = (sel == 8)  && drv_iv_load;
  assign b32.iv_load   = (sel == 32) && drv_iv_load;
  assign b64.in_data   = drv_in_data;
  assign b8.in_data    = drv_in_data[7:0];
  assign b32.in_data   = drv_in_data[31:0];
  assign b64.iv        = drv_iv;
  assign b8.iv         = drv_iv;
  assign b32.iv        = drv_iv;
  assign b64.decrypt   = drv_decrypt;
  assign b8.decrypt    = drv_decrypt;
  assign b32.decrypt   = drv_decrypt;

  logic        sel_in_ready, sel_out_valid, sel_busy;
  logic [63:0] sel_out_data, sel_fb;

  always_comb begin
    sel_in_ready  = b64.in_ready;
    sel_out_valid = b64.out_valid;
    sel_busy      = busy64;
    sel_out_data  = b64.out_data;
    sel_fb        = dut64.fb_q;
    if (sel == 8) begin
      sel_in_ready  = b8.in_ready;
      sel_out_valid = b8.out_valid;
      sel_busy      = busy8;
      sel_out_data  = {56'd0, b8.out_data};
      sel_fb        = dut8.fb_q;
    end else if (sel == 32) begin
      sel_in_ready  = b32.in_ready;
      sel_out_valid = b32.out_valid;
      sel_busy      = busy32;
      sel_out_data  = {32'd0, b32.out_data};
      sel_fb        = dut32.fb_q;
    end
  end

  // Reference GOST 28147-89 block encryption (N1 = low half, K0 = key MSBs).
  function automatic logic [63:0] gost_enc(input logic [63:0] blk);
    logic [31:0] n1, n2, k, t, s, tmp;
    logic [3:0]  nib;
    n1 = blk[31:0];
    n2 = blk[63:32];
    s  = 32'd0;
    for (int r = 0; r < 32; r++) begin
      int j;
      j = (r < 24) ? (r % 8) : (7 - (r % 8));
      k = key_c[255 - 32*j -: 32];
      t = n1 + k;
      for (int b = 0; b < 8; b++) begin
        nib = t[4*b +: 4];
        s[4*b +: 4] = sbox_c[(b*16 + int'(nib))*4 +: 4];
      end
      tmp = n2 ^ {s[20:0], s[31:21]};
      n2  = n1;
      n1  = tmp;
    end
    return {n1, n2};
  endfunction

  // One CFB segment of the reference: result and updated feedback.
  task automatic model_step(input int w, input logic [63:0] seg, input bit dec,
                            inout logic [63:0] fb, output logic [63:0] res);
    logic [63:0] mask, c;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    res  = ((gost_enc(fb) >> (64 - w)) ^ seg) & mask;
    c    = dec ? (seg & mask) : res;
    fb   = (w == 64) ? c : ((fb << w) | c);
  endtask

  task automatic load_iv(input logic [63:0] iv, input bit dec);
    drv_iv_load = 1'b1;
    drv_iv      = iv;
    drv_decrypt = dec;
    @(posedge clk); #1;
    drv_iv_load = 1'b0;
  endtask

  // Full transfer of one segment; optionally pulses iv_load mid-computation.
  task automatic xfer(input logic [63:0] din, input bit iv_mid, input logic [63:0] iv_alt,
                      output logic [63:0] dout);
    int n;
    n = 0;
    while (!sel_in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!sel_in_ready) begin
      $display("FAIL xfer_in_ready_timeout got=%0b exp=1", sel_in_ready);
      failures++;
    end
    drv_in_valid = 1'b1;
    drv_in_data  = din;
    @(posedge clk); #1;
    drv_in_valid = 1'b0;
    n = 0;
    while (!sel_out_valid && n < 200) begin
      if (iv_mid && n == 5) begin
        drv_iv_load = 1'b1;
        drv_iv      = iv_alt;
        drv_decrypt = 1'b1;
      end else begin
        drv_iv_load = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    drv_iv_load = 1'b0;
    checks++;
    if (!sel_out_valid) begin
      $display("FAIL xfer_out_valid_timeout got=%0b exp=1", sel_out_valid);
      failures++;
    end
    dout = sel_out_data;
    drv_out_ready = 1'b1;
    @(posedge clk); #1;
    drv_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    if (b64.out_valid !== 1'b0 || busy64 !== 1'b0 || b64.out_data !== 64'd0) begin
      $display("FAIL reset_64_outputs got=%0b/%0b/%h exp=0/0/0", b64.out_valid, busy64, b64.out_data);
      failures++;
    end
    checks++;
    if (dut64.fb_q !== 64'd0) begin
      $display("FAIL reset_64_fb got=%h exp=0", dut64.fb_q);
      failures++;
    end
    checks++;
    if (b64.in_ready !== 1'b1) begin
      $display("FAIL reset_64_in_ready got=%0b exp=1", b64.in_ready);
      failures++;
    end
    checks++;
    if (b8.out_valid !== 1'b0 || busy8 !== 1'b0 || b8.out_data !== 8'd0 || dut8.fb_q !== 64'd0) begin
      $display("FAIL reset_8_state got=%0b/%0b/%h/%h exp=0/0/0/0", b8.out_valid, busy8, b8.out_data, dut8.fb_q);
      failures++;
    end
    checks++;
    if (b32.out_valid !== 1'b0 || busy32 !== 1'b0 || b32.out_data !== 32'd0 || b32.in_ready !== 1'b1) begin
      $display("FAIL reset_32_state got=%0b/%0b/%h/%0b exp=0/0/0/1", b32.out_valid, busy32, b32.out_data, b32.in_ready);
      failures++;
    end
    checks++;
    $display("test_reset done checks=%0d", checks);
  endtask

  task automatic test_cfb64();
    logic [63:0] m_fb, exp, got;
    sel = 64;
    load_iv(IV0, 1'b0);
    m_fb = IV0;
    xfer(64'd0, 1'b0, 64'd0, got);
    model_step(64, 64'd0, 1'b0, m_fb, exp);
    checks++;
    if (got !== exp) begin
      $display("FAIL cfb64_seg0 got=%h exp=%h", got, exp);
      failures++;
    end
    $display("cfb64 seg0 in=%h out=%h", 64'd0, got);
    checks++;
    if (sel_fb !== m_fb) begin
      $display("FAIL cfb64_fb0 got=%h exp=%h", sel_fb, m_fb);
      failures++;
    end
    xfer(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd0, got);
    model_step(64, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, m_fb, exp);
    checks++;
    if (got !== exp) begin
      $display("FAIL cfb64_seg1 got=%h exp=%h", got, exp);
      failures++;
    end
    $display("cfb64 seg1 in=%h out=%h", 64'hFFFF_FFFF_FFFF_FFFF, got);
  endtask

  task automatic test_cfb8_roundtrip();
    logic [63:0] m_fb, exp, got;
    logic [7:0]  ct [16];
    sel = 8;
    load_iv(IV0, 1'b0);
    m_fb = IV0;
    for (int i = 0; i < 16; i++) begin
      xfer(64'(i), 1'b0, 64'd0, got);
      model_step(8, 64'(i), 1'b0, m_fb, exp);
      ct[i] = got[7:0];
      checks++;
      if (got !== exp) begin
        $display("FAIL cfb8_enc_%0d got=%h exp=%h", i, got, exp);
        failures++;
      end
      $display("cfb8 enc %0d in=%h out=%h", i, i[7:0], got[7:0]);
      if (i == 0) begin
        checks++;
        if (sel_fb !== {IV0[55:0], ct[0]}) begin
          $display("FAIL cfb8_fb_after_seg0 got=%h exp=%h", sel_fb, {IV0[55:0], ct[0]});
          failures++;
        end
      end
    end
    load_iv(IV0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      xfer({56'd0, ct[i]}, 1'b0, 64'd0, got);
      checks++;
      if (got[7:0] !== 8'(i)) begin
        $display("FAIL cfb8_dec_%0d got=%h exp=%h", i, got[7:0], 8'(i));
        failures++;
      end
      $display("cfb8 dec %0d in=%h out=%h", i, ct[i], got[7:0]);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] m_fb, exp, held;
    int n, hs;
    sel = 32;
    load_iv(IV1, 1'b0);
    m_fb = IV1;
    drv_in_valid = 1'b1;
    drv_in_data  = 64'h0000_0000_DEAD_BEEF;
    @(posedge clk); #1;
    drv_in_valid = 1'b0;
    n = 0;
    while (!sel_out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    model_step(32, 64'h0000_0000_DEAD_BEEF, 1'b0, m_fb, exp);
    checks++;
    if (!sel_out_valid || sel_out_data !== exp) begin
      $display("FAIL bp_first_result got=%0b/%h exp=1/%h", sel_out_valid, sel_out_data, exp);
      failures++;
    end
    held = exp;
    for (int c = 0; c < 20; c++) begin
      drv_in_valid = c[0];
      drv_in_data  = 64'(c) * 64'h0101_0101;
      @(posedge clk); #1;
      checks++;
      if (sel_out_valid !== 1'b1 || sel_out_data !== held || sel_in_ready !== 1'b0) begin
        $display("FAIL bp_hold_%0d got=%0b/%h/%0b exp=1/%h/0", c, sel_out_valid, sel_out_data, sel_in_ready, held);
        failures++;
      end
    end
    drv_in_valid  = 1'b0;
    drv_out_ready = 1'b1;
    hs = 0;
    for (int c = 0; c < 5; c++) begin
      if (sel_out_valid && drv_out_ready) hs++;
      @(posedge clk); #1;
    end
    drv_out_ready = 1'b0;
    checks++;
    if (hs != 1) begin
      $display("FAIL bp_handshakes got=%0d exp=1", hs);
      failures++;
    end
    checks++;
    if (sel_busy !== 1'b0 || sel_out_valid !== 1'b0) begin
      $display("FAIL bp_idle_after got=%0b/%0b exp=0/0", sel_busy, sel_out_valid);
      failures++;
    end
    checks++;
    if (sel_fb !== m_fb) begin
      $display("FAIL bp_fb got=%h exp=%h", sel_fb, m_fb);
      failures++;
    end
    $display("backpressure seg out=%h handshakes=%0d", held[31:0], hs);
  endtask

  task automatic test_iv_ignore();
    logic [63:0] m_fb, exp, got;
    sel = 32;
    load_iv(IV1, 1'b0);
    m_fb = IV1;
    xfer(64'h0000_0000_1234_5678, 1'b1, IV2, got);
    model_step(32, 64'h0000_0000_1234_5678, 1'b0, m_fb, exp);
    checks++;
    if (got !== exp) begin
      $display("FAIL iv_in_wait_result got=%h exp=%h", got, exp);
      failures++;
    end
    checks++;
    if (sel_fb !== m_fb) begin
      $display("FAIL iv_in_wait_fb got=%h exp=%h", sel_fb, m_fb);
      failures++;
    end
    $display("iv_load in WAIT ignored out=%h", got[31:0]);
    drv_iv_load  = 1'b1;
    drv_iv       = IV2;
    drv_decrypt  = 1'b0;
    drv_in_valid = 1'b1;
    drv_in_data  = 64'h0000_0000_CAFE_F00D;
    #1;
    checks++;
    if (sel_in_ready !== 1'b0) begin
      $display("FAIL iv_with_valid_in_ready got=%0b exp=0", sel_in_ready);
      failures++;
    end
    @(posedge clk); #1;
    drv_iv_load  = 1'b0;
    drv_in_valid = 1'b0;
    checks++;
    if (sel_busy !== 1'b0 || sel_fb !== IV2) begin
      $display("FAIL iv_with_valid_state got=%0b/%h exp=0/%h", sel_busy, sel_fb, IV2);
      failures++;
    end
    m_fb = IV2;
    xfer(64'h0000_0000_CAFE_F00D, 1'b0, 64'd0, got);
    model_step(32, 64'h0000_0000_CAFE_F00D, 1'b0, m_fb, exp);
    checks++;
    if (got !== exp) begin
      $display("FAIL iv_with_valid_next got=%h exp=%h", got, exp);
      failures++;
    end
    $display("iv_load with in_valid: segment deferred out=%h", got[31:0]);
  endtask

  task automatic test_reset_mid();
    logic [63:0] m_fb, exp, got;
    sel = 64;
    load_iv(IV2, 1'b0);
    drv_in_valid = 1'b1;
    drv_in_data  = 64'h1111_2222_3333_4444;
    @(posedge clk); #1;
    drv_in_valid = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    checks++;
    if (sel_busy !== 1'b1) begin
      $display("FAIL reset_mid_busy_before got=%0b exp=1", sel_busy);
      failures++;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (sel_out_valid !== 1'b0 || sel_busy !== 1'b0 || sel_fb !== 64'd0) begin
      $display("FAIL reset_mid_state got=%0b/%0b/%h exp=0/0/0", sel_out_valid, sel_busy, sel_fb);
      failures++;
    end
    load_iv(IV0, 1'b0);
    m_fb = IV0;
    xfer(64'h5555_AAAA_5555_AAAA, 1'b0, 64'd0, got);
    model_step(64, 64'h5555_AAAA_5555_AAAA, 1'b0, m_fb, exp);
    checks++;
    if (got !== exp) begin
      $display("FAIL reset_mid_fresh got=%h exp=%h", got, exp);
      failures++;
    end
    $display("reset in WAIT then fresh seg out=%h", got);
  endtask

`ifdef GOST89_CFB_SEGCNT_EN
  task automatic test_segcnt();
    logic [63:0] got;
    sel = 8;
    load_iv(IV1, 1'b0);
    checks++;
    if (cnt8 !== 32'd0) begin
      $display("FAIL segcnt_after_iv got=%0d exp=0", cnt8);
      failures++;
    end
    for (int i = 0; i < 5; i++) xfer(64'(i), 1'b0, 64'd0, got);
    checks++;
    if (cnt8 !== 32'd5) begin
      $display("FAIL segcnt_five got=%0d exp=5", cnt8);
      failures++;
    end
    load_iv(IV1, 1'b0);
    checks++;
    if (cnt8 !== 32'd0) begin
      $display("FAIL segcnt_clear got=%0d exp=0", cnt8);
      failures++;
    end
    force dut8.cnt_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut8.cnt_q;
    @(posedge clk); #1;
    xfer(64'h42, 1'b0, 64'd0, got);
    checks++;
    if (cnt8 !== 32'd0) begin
      $display("FAIL segcnt_wrap got=%h exp=0", cnt8);
      failures++;
    end
    $display("seg_count wrap result=%h", cnt8);
  endtask
`endif

  initial begin
    checks        = 0;
    failures      = 0;
    sel           = 64;
    reset         = 1'b1;
    drv_in_valid  = 1'b0;
    drv_out_ready = 1'b0;
    drv_iv_load   = 1'b0;
    drv_decrypt   = 1'b0;
    drv_in_data   = 64'd0;
    drv_iv        = 64'd0;
    key_c = 256'h0011223344556677_8899AABBCCDDEEFF_FFEEDDCCBBAA9988_7766554433221100;
    for (int b = 0; b < 8; b++) begin
      for (int v = 0; v < 16; v++) begin
        sbox_c[(b*16 + v)*4 +: 4] = 4'((v*7 + b*3 + 5) % 16);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    test_reset();
    test_cfb64();
    test_cfb8_roundtrip();
    test_backpressure();
    test_iv_ignore();
    test_reset_mid();
`ifdef GOST89_CFB_SEGCNT_EN
    test_segcnt();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
